wb_regfile: RTL and testbench
=============================

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register and data width.
REQ-002 SHALL have parameter NREG, default 32: register count; address width is log2(NREG) = 5.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port RegWrite, input, 1: write-back enable from the MEM/WB register.
REQ-006 SHALL have port MemtoReg, input, 2: write-back source select.
REQ-007 SHALL have port ALU_out, input, 32: ALU result.
REQ-008 SHALL have port RD_out, input, 32: memory load data.
REQ-009 SHALL have port pc_next_out, input, 32: link address (PC+4).
REQ-010 SHALL have port WN_out, input, 5: destination register number.
REQ-011 SHALL have port RN1, input, 5: read address, port 1.
REQ-012 SHALL have port RN2, input, 5: read address, port 2.
REQ-013 SHALL have port RD1, output, 32: read data, port 1.
REQ-014 SHALL have port RD2, output, 32: read data, port 2.
REQ-015 SHALL have port WD, output, 32: selected write-back data, for the forwarding unit.
REQ-016 SHALL have port wr_count, output, 32: count of committed register writes.

Function
REQ-017 WD SHALL be combinational on MemtoReg: 00 selects ALU_out, 01 selects RD_out, 10 selects pc_next_out, 11 (reserved) selects ALU_out.
REQ-018 An effective write SHALL occur when RegWrite=1, WN_out!=0 and reset=0.
REQ-019 An effective write SHALL store WD into register[WN_out] at the rising clk edge.
REQ-020 Register 0 SHALL never be written; any read of address 0 SHALL return 0.
REQ-021 Reads on RD1/RD2 SHALL be combinational, with zero-cycle latency from RN1/RN2.
REQ-022 Write-first bypass: when an effective write is pending and WN_out equals RNx (RNx!=0), RDx SHALL equal WD in that same cycle.
REQ-023 Both read ports matching the write address SHALL both bypass; RN1=RN2 SHALL return identical data.
REQ-024 wr_count SHALL increment by 1 on each effective write.
REQ-025 wr_count SHALL wrap from 0xFFFFFFFF to 0 without flagging.
REQ-026 RegWrite=1 with WN_out=0 SHALL change neither the register array nor wr_count.
REQ-027 X/unknown values on MemtoReg SHALL not corrupt the array when RegWrite=0.

Reset
REQ-028 Asserting reset SHALL immediately clear all NREG registers and wr_count to 0, independent of clk.
REQ-029 While reset=1, writes SHALL be suppressed and RD1/RD2 SHALL read 0.
REQ-030 While reset=1, WD SHALL remain the combinational mux output.
REQ-031 Reset asserted in the same cycle as a pending write SHALL discard that write.
REQ-032 The first write SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-033 A shared package SHALL hold the MemtoReg encodings (WB_SEL_ALU=00, WB_SEL_MEM=01, WB_SEL_PC=10), DATA_W and the register-address width.
REQ-034 The write-back data select SHALL be a separate combinational sub-module named wb_data_mux.
REQ-035 The register array, bypass logic and counter SHALL reside in wb_regfile.

Verification
REQ-036 Reset, then read RN1=5, RN2=31 -> RD1=RD2=0 and wr_count=0.
REQ-037 RegWrite=1, MemtoReg=01, RD_out=0xDEADBEEF, WN_out=7 with RN1=7 in the same cycle -> RD1=0xDEADBEEF (bypass); RN1=7 next cycle -> 0xDEADBEEF; wr_count=1.
REQ-038 MemtoReg=10, pc_next_out=0x00400010, WN_out=31 -> reg31=0x00400010; MemtoReg=11 with ALU_out=0x5 -> WD=0x5.
REQ-039 RegWrite=1, WN_out=0, ALU_out=0xFFFFFFFF -> RD1 at RN1=0 reads 0; wr_count unchanged.
REQ-040 Preload wr_count=0xFFFFFFFF (force), perform one effective write -> wr_count=0.
REQ-041 Write reg3=0x1234, then pulse reset mid-cycle with a write pending to reg4 -> reg3=0, reg4=0 and wr_count=0 immediately.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg
//   Shared constants for the write-back register file: data width,
//   register-address width and the MemtoReg write-back source encodings.
package wb_regfile_pkg;

  localparam int DATA_W = 32;
  localparam int NREG   = 32;
  localparam int AW     = $clog2(NREG);

  typedef enum logic [1:0] {
    WB_SEL_ALU = 2'b00,
    WB_SEL_MEM = 2'b01,
    WB_SEL_PC  = 2'b10,
    WB_SEL_RSV = 2'b11
  } wb_sel_e;

endpackage

// File: rtl/wb_regfile_mux.sv
// wb_data_mux
//   Combinational write-back source select.
//   Ports:
//     i_sel  - MemtoReg select (ALU / MEM / PC; reserved code falls back to ALU)
//     i_alu  - ALU result
//     i_mem  - memory load data
//     i_pc   - link address (PC+4)
//     o_wd   - selected write-back data
module wb_data_mux
  import wb_regfile_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic [1:0]   i_sel,
  input  logic [W-1:0] i_alu,
  input  logic [W-1:0] i_mem,
  input  logic [W-1:0] i_pc,
  output logic [W-1:0] o_wd
);

  always_comb begin
    o_wd = i_alu;
    unique case (wb_sel_e'(i_sel))
      WB_SEL_MEM: o_wd = i_mem;
      WB_SEL_PC:  o_wd = i_pc;
      default:    o_wd = i_alu;  // ALU and the reserved code
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile
//   Two-read / one-write register file for the write-back stage, with
//   write-first bypass, hard-wired zero register and a committed-write counter.
//   Ports:
//     clk, reset       - clock; asynchronous active-high reset
//     RegWrite         - write-back enable from MEM/WB
//     MemtoReg         - write-back source select
//     ALU_out, RD_out,
//     pc_next_out      - write-back source candidates
//     WN_out           - destination register number
//     RN1, RN2         - read addresses
//     RD1, RD2         - read data (combinational, bypassed)
//     WD               - selected write-back data (to forwarding unit)
//     wr_count         - number of effective writes, wraps silently
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = wb_regfile_pkg::DATA_W,
  parameter int NREG   = wb_regfile_pkg::NREG,
  localparam int AW    = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [1:0]        MemtoReg,
  input  logic [DATA_W-1:0] ALU_out,
  input  logic [DATA_W-1:0] RD_out,
  input  logic [DATA_W-1:0] pc_next_out,
  input  logic [AW-1:0]     WN_out,
  input  logic [AW-1:0]     RN1,
  input  logic [AW-1:0]     RN2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic [DATA_W-1:0] WD,
  output logic [31:0]       wr_count
);

  logic [NREG-1:0][DATA_W-1:0] r_regs;
  logic [31:0]                 r_wr_count;
  logic                        w_we;
  logic [1:0][AW-1:0]          w_rn;
  logic [1:0][DATA_W-1:0]      w_rd;

  wb_data_mux #(.W(DATA_W)) u_mux (
    .i_sel (MemtoReg),
    .i_alu (ALU_out),
    .i_mem (RD_out),
    .i_pc  (pc_next_out),
    .o_wd  (WD)
  );

  // Qualify with reset so a write pending when reset rises is dropped and
  // the bypass path cannot leak WD onto the read ports during reset.
  assign w_we = RegWrite && (WN_out != '0) && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_regs     <= '0;
      r_wr_count <= '0;
    end else if (w_we) begin
      r_regs[WN_out] <= WD;
      r_wr_count     <= r_wr_count + 32'd1;
    end
  end

  assign w_rn = {RN2, RN1};

  // Read priority: reset / address 0 force zero, then write-first bypass,
  // then array contents.
  for (genvar p = 0; p < 2; p++) begin : g_rd
    always_comb begin
      w_rd[p] = r_regs[w_rn[p]];
      if (reset || w_rn[p] == '0)
        w_rd[p] = '0;
      else if (w_we && WN_out == w_rn[p])
        w_rd[p] = WD;
    end
  end

  assign RD1      = w_rd[0];
  assign RD2      = w_rd[1];
  assign wr_count = r_wr_count;

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWrite;
  logic [1:0]  MemtoReg;
  logic [31:0] ALU_out, RD_out, pc_next_out;
  logic [4:0]  WN_out, RN1, RN2;
  logic [31:0] RD1, RD2, WD, wr_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .reset(reset), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .ALU_out(ALU_out), .RD_out(RD_out), .pc_next_out(pc_next_out),
    .WN_out(WN_out), .RN1(RN1), .RN2(RN2),
    .RD1(RD1), .RD2(RD2), .WD(WD), .wr_count(wr_count)
  );

  typedef struct {
    logic        rw;
    logic [1:0]  sel;
    logic [31:0] alu, mem, pc;
    logic [4:0]  wn, rn1, rn2;
    logic [31:0] e_rd1, e_rd2, e_wd, e_cnt;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rw, input logic [1:0] sel, input logic [31:0] alu,
                       input logic [31:0] mem, input logic [31:0] pc, input logic [4:0] wn,
                       input logic [4:0] rn1, input logic [4:0] rn2);
    RegWrite = rw; MemtoReg = sel; ALU_out = alu; RD_out = mem; pc_next_out = pc;
    WN_out = wn; RN1 = rn1; RN2 = rn2;
  endtask

  vec_t tbl [10];

  initial begin
    // Expected values are applied before the rising edge, so counts and reads
    // reflect writes committed by earlier vectors (plus same-cycle bypass).
    tbl[0] = '{1'b0, 2'b00, 32'h0,        32'h0,        32'h0,        5'd0,  5'd5,  5'd31, 32'h0,        32'h0,        32'h0,        32'd0};
    tbl[1] = '{1'b1, 2'b01, 32'h0,        32'hDEADBEEF, 32'h0,        5'd7,  5'd7,  5'd0,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'd0};
    tbl[2] = '{1'b0, 2'b00, 32'h11,       32'h0,        32'h0,        5'd7,  5'd7,  5'd7,  32'hDEADBEEF, 32'hDEADBEEF, 32'h11,       32'd1};
    tbl[3] = '{1'b1, 2'b10, 32'h0,        32'h0,        32'h00400010, 5'd31, 5'd7,  5'd31, 32'hDEADBEEF, 32'h00400010, 32'h00400010, 32'd1};
    tbl[4] = '{1'b0, 2'b11, 32'h5,        32'h9,        32'h8,        5'd31, 5'd31, 5'd7,  32'h00400010, 32'hDEADBEEF, 32'h5,        32'd2};
    tbl[5] = '{1'b1, 2'b11, 32'h5,        32'h9,        32'h8,        5'd9,  5'd9,  5'd9,  32'h5,        32'h5,        32'h5,        32'd2};
    tbl[6] = '{1'b1, 2'b00, 32'hFFFFFFFF, 32'h0,        32'h0,        5'd0,  5'd0,  5'd9,  32'h0,        32'h5,        32'hFFFFFFFF, 32'd3};
    tbl[7] = '{1'b0, 2'b00, 32'h0,        32'h0,        32'h0,        5'd0,  5'd0,  5'd9,  32'h0,        32'h5,        32'h0,        32'd3};
    tbl[8] = '{1'b1, 2'b00, 32'hAAAA5555, 32'h0,        32'h0,        5'd9,  5'd9,  5'd7,  32'hAAAA5555, 32'hDEADBEEF, 32'hAAAA5555, 32'd3};
    tbl[9] = '{1'b0, 2'b01, 32'h0,        32'hCAFE0000, 32'h0,        5'd9,  5'd9,  5'd31, 32'hAAAA5555, 32'h00400010, 32'hCAFE0000, 32'd4};

    reset = 1'b1;
    drive(1'b1, 2'b00, 32'h1, 32'h0, 32'h0, 5'd5, 5'd5, 5'd31);
    #2;
    chk("rst_rd1", RD1, 32'h0);
    chk("rst_rd2", RD2, 32'h0);
    chk("rst_cnt", wr_count, 32'h0);
    chk("rst_wd", WD, 32'h1);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].rw, tbl[i].sel, tbl[i].alu, tbl[i].mem, tbl[i].pc,
            tbl[i].wn, tbl[i].rn1, tbl[i].rn2);
      #1;
      chk($sformatf("v%0d_rd1", i), RD1, tbl[i].e_rd1);
      chk($sformatf("v%0d_rd2", i), RD2, tbl[i].e_rd2);
      chk($sformatf("v%0d_wd",  i), WD,  tbl[i].e_wd);
      chk($sformatf("v%0d_cnt", i), wr_count, tbl[i].e_cnt);
      @(negedge clk);
    end

    // Counter wrap: preload all-ones, one effective write rolls to zero.
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    force dut.r_wr_count = 32'hFFFFFFFF;
    #1;
    release dut.r_wr_count;
    #1;
    chk("wrap_pre", wr_count, 32'hFFFFFFFF);
    drive(1'b1, 2'b00, 32'h1, 32'h0, 32'h0, 5'd10, 5'd10, 5'd0);
    @(negedge clk);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd10, 5'd0);
    #1;
    chk("wrap_cnt", wr_count, 32'h0);
    chk("wrap_reg10", RD1, 32'h1);

    // Reset arriving mid-cycle with a write pending.
    @(negedge clk);
    drive(1'b1, 2'b00, 32'h1234, 32'h0, 32'h0, 5'd3, 5'd0, 5'd0);
    @(negedge clk);
    drive(1'b1, 2'b00, 32'h5678, 32'h0, 32'h0, 5'd4, 5'd3, 5'd4);
    #1;
    chk("pre_rst_reg3", RD1, 32'h1234);
    chk("pre_rst_byp4", RD2, 32'h5678);
    chk("pre_rst_cnt", wr_count, 32'h1);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_rd1", RD1, 32'h0);
    chk("mid_rst_rd2", RD2, 32'h0);
    chk("mid_rst_cnt", wr_count, 32'h0);
    chk("mid_rst_wd", WD, 32'h5678);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd4);
    #1;
    chk("post_rst_reg3", RD1, 32'h0);
    chk("post_rst_reg4", RD2, 32'h0);
    chk("post_rst_cnt", wr_count, 32'h0);

    // First write right after reset release is accepted.
    drive(1'b1, 2'b01, 32'h0, 32'h77, 32'h0, 5'd4, 5'd3, 5'd4);
    @(negedge clk);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd4);
    #1;
    chk("first_wr_reg4", RD2, 32'h77);
    chk("first_wr_reg3", RD1, 32'h0);
    chk("first_wr_cnt", wr_count, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
